// File: rtl/avr_intc_pkg.sv
// -----------------------------------------------------------------------------
// avr_intc_pkg
// Shared definitions for the avr_intc interrupt controller:
//   - NSRC / VW      : number of sources and vector width
//   - OFS_*          : byte offsets of the 4-byte register window
//   - CTRL_*         : bit positions inside the CTRL register
//   - state_e        : request FSM encoding (IDLE, REQ, GAP)
// -----------------------------------------------------------------------------
package avr_intc_pkg;

   localparam int NSRC = 8;
   localparam int VW   = 3;

   localparam logic [1:0] OFS_MASK = 2'd0;
   localparam logic [1:0] OFS_PEND = 2'd1;
   localparam logic [1:0] OFS_CTRL = 2'd2;
   localparam logic [1:0] OFS_SWI  = 2'd3;

   localparam int CTRL_GIE_BIT  = 0;
   localparam int CTRL_INTR_BIT = 4;
   localparam int CTRL_VECT_LSB = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

endpackage

// File: rtl/avr_intc_prio.sv
// -----------------------------------------------------------------------------
// avr_intc_prio
// Combinational 8-to-3 priority encoder.
//   req_i    [7:0] : candidate requests (pend & mask)
//   start_i  [2:0] : index where the search begins (rotation only)
//   winner_o [2:0] : selected index (0 when nothing is requested)
//   any_o          : at least one request present
// Macro AVR_INTC_ROTATE_EN: when defined the search starts at start_i and
// wraps modulo 8; otherwise index 0 is always highest and start_i is ignored.
// -----------------------------------------------------------------------------
module avr_intc_prio
   import avr_intc_pkg::*;
(
   input  logic [NSRC-1:0] req_i,
   input  logic [VW-1:0]   start_i,
   output logic [VW-1:0]   winner_o,
   output logic            any_o
);

`ifdef AVR_INTC_ROTATE_EN
   // Scan from the farthest position back toward start_i so the last hit
   // written is the first one in rotated order.
   always_comb begin
      winner_o = '0;
      any_o    = |req_i;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req_i[start_i + VW'(i)]) begin
            winner_o = start_i + VW'(i);
         end
      end
   end
`else
   logic unused_start;
   assign unused_start = ^start_i;

   always_comb begin
      winner_o = '0;
      any_o    = |req_i;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            winner_o = VW'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/avr_intc.sv
// -----------------------------------------------------------------------------
// avr_intc
// 8-source interrupt controller driving the AVR core intr/vect pair.
// Rising edges on src are synchronised, latched as pending, masked and
// prioritised; one vector is presented until the core acknowledges it.
//
// Ports:
//   clock, reset_n   : clock, synchronous active-low reset
//   ce               : clock enable for the FSM and register writes
//   src    [7:0]     : asynchronous interrupt lines (rising edge requests)
//   address[15:0]    : CPU data address
//   wdata  [7:0], we : CPU write data / strobe
//   rdata  [7:0]     : register read data (combinational, 0 when not hit)
//   hit              : address inside BASE..BASE+3
//   intr, vect [2:0] : request and vector to the core
//   ack              : one-cycle take pulse from the core
//   dbg_state_o      : current FSM state
//
// Handshake: intr rises with vect already valid; vect is stable while intr=1.
// A single-cycle ack while intr=1 retires the vector; intr then stays low for
// at least one cycle. ack while intr=0 is ignored. Software may withdraw a
// request (W1C, mask or GIE), which drops intr without an ack.
//
// Register window (BASE must be 4-aligned):
//   +0 MASK RW, +1 PEND R/W1C, +2 CTRL {vect,intr,000,gie}, +3 SWI W1S
//
// Macro AVR_INTC_ROTATE_EN: round-robin arbitration with a start pointer
// (served vect + 1, updated on ack). Undefined: fixed priority, 0 highest.
// -----------------------------------------------------------------------------
module avr_intc
   import avr_intc_pkg::*;
#(
   parameter logic [15:0] BASE = 16'h0030
)(
   input  logic            clock,
   input  logic            reset_n,
   input  logic            ce,
   input  logic [NSRC-1:0] src,
   input  logic [15:0]     address,
   input  logic [7:0]      wdata,
   input  logic            we,
   output logic [7:0]      rdata,
   output logic            hit,
   output logic            intr,
   output logic [VW-1:0]   vect,
   input  logic            ack,
   output state_e          dbg_state_o
);

   // input path
   logic [NSRC-1:0] s1_q, s2_q, s3_q;
   logic [NSRC-1:0] rise;

   // software-visible state
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic            gie_q,  gie_d;

   // request FSM
   state_e          state_q, state_d;
   logic [VW-1:0]   vect_q,  vect_d;
   logic            ack_take;

   // arbitration
   logic [VW-1:0]   start;
   logic [VW-1:0]   winner;
   logic            any_req;

   // bus decode
   logic [1:0]      ofs;
   logic            wr_en;

   assign rise = s2_q & ~s3_q;

   // Comparing only the upper 14 bits keeps the window exactly four bytes;
   // nothing outside BASE..BASE+3 can alias into it.
   assign hit   = (address[15:2] == BASE[15:2]);
   assign ofs   = address[1:0];
   assign wr_en = ce & we & hit;

   always_comb begin
      rdata = 8'h00;
      if (hit) begin
         case (ofs)
            OFS_MASK: rdata = mask_q;
            OFS_PEND: rdata = pend_q;
            OFS_CTRL: begin
               rdata[CTRL_GIE_BIT]                   = gie_q;
               rdata[CTRL_INTR_BIT]                  = intr;
               rdata[CTRL_VECT_LSB +: VW]            = vect_q;
            end
            default:  rdata = 8'h00;
         endcase
      end
   end

`ifdef AVR_INTC_ROTATE_EN
   logic [VW-1:0] ptr_q, ptr_d;

   assign ptr_d = ack_take ? (vect_q + VW'(1)) : ptr_q;
   assign start = ptr_q;

   always_ff @(posedge clock) begin
      if (!reset_n) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end
`else
   assign start = '0;
`endif

   avr_intc_prio u_prio (
      .req_i    (pend_q & mask_q),
      .start_i  (start),
      .winner_o (winner),
      .any_o    (any_req)
   );

   // FSM next state. ce=0 holds everything here.
   always_comb begin
      state_d  = state_q;
      vect_d   = vect_q;
      ack_take = 1'b0;
      if (ce) begin
         case (state_q)
            ST_IDLE: begin
               if (gie_q && any_req) begin
                  state_d = ST_REQ;
                  vect_d  = winner;
               end
            end
            ST_REQ: begin
               if (ack) begin
                  state_d  = ST_GAP;
                  ack_take = 1'b1;
               end else if (!(pend_q[vect_q] && mask_q[vect_q] && gie_q)) begin
                  // software withdrew the request; vect keeps its last value
                  state_d = ST_IDLE;
               end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Pending bits: clears are applied first so that a same-cycle hardware
   // edge or SWI set of the same bit wins.
   always_comb begin
      pend_d = pend_q;
      if (wr_en && ofs == OFS_PEND) pend_d = pend_d & ~wdata;
      if (ack_take)                 pend_d[vect_q] = 1'b0;
      pend_d = pend_d | rise;
      if (wr_en && ofs == OFS_SWI)  pend_d = pend_d | wdata;
   end

   always_comb begin
      mask_d = mask_q;
      gie_d  = gie_q;
      if (wr_en && ofs == OFS_MASK) mask_d = wdata;
      if (wr_en && ofs == OFS_CTRL) gie_d  = wdata[CTRL_GIE_BIT];
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
         gie_q   <= 1'b0;
         state_q <= ST_IDLE;
         vect_q  <= '0;
      end else begin
         s1_q    <= src;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         gie_q   <= gie_d;
         state_q <= state_d;
         vect_q  <= vect_d;
      end
   end

   assign intr        = (state_q == ST_REQ);
   assign vect        = vect_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_avr_intc.sv
// -----------------------------------------------------------------------------
// tb_avr_intc
// Directed bench for avr_intc: a table of register-window read vectors plus
// hand-written sequences for latency, priority, withdraw, ack/edge collision,
// arbitration order, reset during a request and clock-enable freezing.
// -----------------------------------------------------------------------------
module tb_avr_intc;
   import avr_intc_pkg::*;

   localparam logic [15:0] BASE = 16'h0030;

   logic        clock;
   logic        reset_n;
   logic        ce;
   logic [7:0]  src;
   logic [15:0] address;
   logic [7:0]  wdata;
   logic        we;
   logic [7:0]  rdata;
   logic        hit;
   logic        intr;
   logic [2:0]  vect;
   logic        ack;
   state_e      dbg_state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] addr;
      logic        exp_hit;
      logic [7:0]  exp_rdata;
   } vec_t;

   vec_t vecs[9];

   avr_intc #(.BASE(BASE)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ce          (ce),
      .src         (src),
      .address     (address),
      .wdata       (wdata),
      .we          (we),
      .rdata       (rdata),
      .hit         (hit),
      .intr        (intr),
      .vect        (vect),
      .ack         (ack),
      .dbg_state_o (dbg_state)
   );

   // clock / watchdog
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] ofs, input logic [7:0] data);
      address = BASE + {14'd0, ofs};
      wdata   = data;
      we      = 1'b1;
      tick();
      we      = 1'b0;
      address = 16'h0000;
      wdata   = 8'h00;
   endtask

   task automatic rd_check(input string name, input logic [1:0] ofs, input logic [7:0] exp);
      address = BASE + {14'd0, ofs};
      #1;
      check(name, {24'd0, rdata}, {24'd0, exp});
      address = 16'h0000;
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      logic [2:0] exp_v;

      vecs[0] = '{16'h0030, 1'b1, 8'hA5};
      vecs[1] = '{16'h0031, 1'b1, 8'h42};
      vecs[2] = '{16'h0032, 1'b1, 8'h01};
      vecs[3] = '{16'h0033, 1'b1, 8'h00};
      vecs[4] = '{16'h002F, 1'b0, 8'h00};
      vecs[5] = '{16'h0034, 1'b0, 8'h00};
      vecs[6] = '{16'h0000, 1'b0, 8'h00};
      vecs[7] = '{16'hFFFF, 1'b0, 8'h00};
      vecs[8] = '{16'h1030, 1'b0, 8'h00};

      reset_n = 1'b0; ce = 1'b1; src = 8'h00; address = 16'h0000;
      wdata = 8'h00; we = 1'b0; ack = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      check("rst_intr",  {31'd0, intr}, 32'd0);
      check("rst_vect",  {29'd0, vect}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      rd_check("rst_mask", OFS_MASK, 8'h00);
      rd_check("rst_pend", OFS_PEND, 8'h00);
      rd_check("rst_ctrl", OFS_CTRL, 8'h00);

      // register window table
      wr(OFS_MASK, 8'hA5);
      wr(OFS_CTRL, 8'h01);
      wr(OFS_SWI,  8'h42);
      for (int i = 0; i < 9; i++) begin
         address = vecs[i].addr;
         #1;
         check($sformatf("tbl_hit_%0d", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
         check($sformatf("tbl_rd_%0d", i), {24'd0, rdata}, {24'd0, vecs[i].exp_rdata});
      end
      address = 16'h0000;
      tick();
      check("tbl_no_intr", {31'd0, intr}, 32'd0);
      wr(OFS_PEND, 8'hFF);
      rd_check("tbl_pend_clr", OFS_PEND, 8'h00);

      // single source latency: src high at edge k
      wr(OFS_MASK, 8'h01);
      src = 8'h01;
      tick();                                   // edge k
      src = 8'h00;
      check("lat_k0_intr", {31'd0, intr}, 32'd0);
      tick();                                   // edge k+1
      rd_check("lat_k1_pend", OFS_PEND, 8'h00);
      tick();                                   // edge k+2
      rd_check("lat_k2_pend", OFS_PEND, 8'h01);
      check("lat_k2_intr", {31'd0, intr}, 32'd0);
      tick();                                   // edge k+3
      check("lat_k3_intr", {31'd0, intr}, 32'd1);
      check("lat_k3_vect", {29'd0, vect}, 32'd0);
      rd_check("lat_ctrl", OFS_CTRL, 8'h11);
      ack_pulse();
      check("ack_intr",  {31'd0, intr}, 32'd0);
      check("ack_gap",   {30'd0, dbg_state}, {30'd0, ST_GAP});
      rd_check("ack_pend", OFS_PEND, 8'h00);
      tick();
      check("gap_idle",  {30'd0, dbg_state}, {30'd0, ST_IDLE});

      // two sources rising together: 2 before 5
      wr(OFS_MASK, 8'hFF);
      src = 8'h24;
      tick();
      src = 8'h00;
      repeat (3) tick();
      check("pr_first_intr", {31'd0, intr}, 32'd1);
      check("pr_first_vect", {29'd0, vect}, 32'd2);
      rd_check("pr_pend", OFS_PEND, 8'h24);
      ack_pulse();
      check("pr_gap_intr", {31'd0, intr}, 32'd0);
      tick();
      check("pr_gap2_intr", {31'd0, intr}, 32'd0);
      tick();
      check("pr_second_intr", {31'd0, intr}, 32'd1);
      check("pr_second_vect", {29'd0, vect}, 32'd5);
      rd_check("pr_ctrl", OFS_CTRL, 8'hB1);
      ack_pulse();
      tick();
      rd_check("pr_pend_done", OFS_PEND, 8'h00);

      // masked edge stays pending, unmask raises intr
      wr(OFS_MASK, 8'h00);
      src = 8'h08;
      tick();
      src = 8'h00;
      repeat (4) tick();
      check("msk_no_intr", {31'd0, intr}, 32'd0);
      rd_check("msk_pend", OFS_PEND, 8'h08);
      wr(OFS_MASK, 8'h08);
      tick();
      check("msk_intr", {31'd0, intr}, 32'd1);
      check("msk_vect", {29'd0, vect}, 32'd3);
      ack_pulse();
      tick();

      // withdraw through W1C while in REQ
      wr(OFS_MASK, 8'h10);
      wr(OFS_SWI,  8'h10);
      tick();
      check("wd_intr", {31'd0, intr}, 32'd1);
      check("wd_vect", {29'd0, vect}, 32'd4);
      wr(OFS_PEND, 8'h10);
      check("wd_still_req", {30'd0, dbg_state}, {30'd0, ST_REQ});
      tick();
      check("wd_drop", {31'd0, intr}, 32'd0);
      check("wd_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      rd_check("wd_ctrl", OFS_CTRL, 8'h81);
      rd_check("wd_pend", OFS_PEND, 8'h00);

      // ack and a fresh edge of the same source in one cycle
      wr(OFS_MASK, 8'h02);
      wr(OFS_SWI,  8'h02);
      tick();
      check("col_req_vect", {29'd0, vect}, 32'd1);
      src = 8'h02;
      tick();                                   // edge k
      src = 8'h00;
      tick();                                   // edge k+1
      ack_pulse();                              // edge k+2: ack and rise together
      check("col_gap", {30'd0, dbg_state}, {30'd0, ST_GAP});
      rd_check("col_pend", OFS_PEND, 8'h02);
      tick();
      tick();
      check("col_reintr", {31'd0, intr}, 32'd1);
      check("col_revect", {29'd0, vect}, 32'd1);
      ack_pulse();
      tick();

      // arbitration order with sources 0 and 1 kept pending
      wr(OFS_MASK, 8'h03);
      wr(OFS_SWI,  8'h03);
      tick();
      for (int n = 0; n < 4; n++) begin
`ifdef AVR_INTC_ROTATE_EN
         exp_v = 3'(n % 2);
`else
         exp_v = 3'd0;
`endif
         check($sformatf("arb_intr_%0d", n), {31'd0, intr}, 32'd1);
         check($sformatf("arb_vect_%0d", n), {29'd0, vect}, {29'd0, exp_v});
         ack_pulse();
         wr(OFS_SWI, 8'h03);
         tick();
      end

      // reset during REQ
      check("rr_pre_intr", {31'd0, intr}, 32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("rr_intr",  {31'd0, intr}, 32'd0);
      check("rr_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check("rr_vect",  {29'd0, vect}, 32'd0);
      rd_check("rr_mask", OFS_MASK, 8'h00);
      rd_check("rr_pend", OFS_PEND, 8'h00);

      // ce=0: register writes frozen, edge capture continues
      ce = 1'b0;
      wr(OFS_MASK, 8'hFF);
      rd_check("ce_mask", OFS_MASK, 8'h00);
      src = 8'h04;
      tick();
      src = 8'h00;
      repeat (3) tick();
      rd_check("ce_pend", OFS_PEND, 8'h04);
      ce = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
